// File: rtl/mmu_port_arbiter_pkg.sv
// Shared types for the MMU port arbiter.
// Word/operation types plus the arbiter FSM encoding.
package mmu_port_arbiter_pkg;

   typedef logic [31:0] Word;

   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_WRITE = 2'd1,
      MEM_AMO   = 2'd2
   } MemoryOperation;

   typedef enum logic {
      ARBITRATE = 1'b0,
      LOCKED    = 1'b1
   } ArbiterState;

endpackage

// File: rtl/mmu_port_arbiter_if.sv
// Bundle of requester-side and downstream MMU channels.
// slave is the arbiter's view, master the environment's view.
interface mmu_port_arbiter_if
#(
   parameter int NUM_PORTS = 2
);
   import mmu_port_arbiter_pkg::*;

   logic           [NUM_PORTS-1:0] port_request_valid_in;
   logic           [NUM_PORTS-1:0] port_request_ready_out;
   Word            [NUM_PORTS-1:0] port_request_address_in;
   MemoryOperation [NUM_PORTS-1:0] port_request_operation_in;
   Word            [NUM_PORTS-1:0] port_request_data_in;
   logic           [NUM_PORTS-1:0] port_response_ready_in;
   logic           [NUM_PORTS-1:0] port_response_valid_out;
   Word                            port_response_data_out;

   logic           mmu_request_ready_in;
   logic           mmu_request_valid_out;
   Word            mmu_request_address_out;
   MemoryOperation mmu_request_operation_out;
   Word            mmu_request_data_out;
   logic           mmu_response_ready_out;
   logic           mmu_response_valid_in;
   Word            mmu_response_data_in;

   modport slave (
      input  port_request_valid_in,
      output port_request_ready_out,
      input  port_request_address_in,
      input  port_request_operation_in,
      input  port_request_data_in,
      input  port_response_ready_in,
      output port_response_valid_out,
      output port_response_data_out,
      input  mmu_request_ready_in,
      output mmu_request_valid_out,
      output mmu_request_address_out,
      output mmu_request_operation_out,
      output mmu_request_data_out,
      output mmu_response_ready_out,
      input  mmu_response_valid_in,
      input  mmu_response_data_in
   );

   modport master (
      output port_request_valid_in,
      input  port_request_ready_out,
      output port_request_address_in,
      output port_request_operation_in,
      output port_request_data_in,
      output port_response_ready_in,
      input  port_response_valid_out,
      input  port_response_data_out,
      output mmu_request_ready_in,
      input  mmu_request_valid_out,
      input  mmu_request_address_out,
      input  mmu_request_operation_out,
      input  mmu_request_data_out,
      input  mmu_response_ready_out,
      output mmu_response_valid_in,
      output mmu_response_data_in
   );

endinterface

// File: rtl/mmu_port_arbiter_route_fifo.sv
// Synchronous FIFO with full/empty/count flags.
// Holds routing tags of requests still awaiting a response.
module mmu_port_arbiter_route_fifo
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
)
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = do_push ? inc(wr_q) : wr_q;
      rd_d  = do_pop ? inc(rd_q) : rd_q;
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (do_push) begin
            mem_q[wr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Round-robin N-to-1 arbiter onto one MMU port.
// Grant is held under backpressure; responses follow issue order.
module mmu_port_arbiter
   import mmu_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int MAX_OUTSTANDING = 4
)
(
   input  logic              clk_in,
   input  logic              rst_n_in,
   mmu_port_arbiter_if.slave bus
);

   localparam int PORT_ID_WIDTH = $clog2(NUM_PORTS);
   localparam int IDW = PORT_ID_WIDTH;
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   typedef logic [IDW-1:0] port_id_t;

   ArbiterState          state_q, state_d;
   port_id_t             rr_q, rr_d;
   port_id_t             lock_q, lock_d;
   port_id_t             rr_sel, sel, head;
   logic                 rr_found;
   logic                 req_valid, push, pop;
   logic                 resp_ready;
   logic                 fifo_full, fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic [NUM_PORTS-1:0] req_ready;
   logic [NUM_PORTS-1:0] resp_valid;
   logic [IDW:0]         probe;

   function automatic port_id_t next_id(input port_id_t id);
      return (id == port_id_t'(NUM_PORTS - 1)) ? '0 : id + 1'b1;
   endfunction

   // Walk downward so the lowest offset from rr_q wins.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      probe    = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         probe = {1'b0, rr_q} + (IDW+1)'(k);
         if (probe >= (IDW+1)'(NUM_PORTS)) begin
            probe = probe - (IDW+1)'(NUM_PORTS);
         end
         if (bus.port_request_valid_in[probe[IDW-1:0]]) begin
            rr_found = 1'b1;
            rr_sel   = probe[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_d    = lock_q;
      rr_d      = rr_q;
      sel       = '0;
      req_valid = 1'b0;
      push      = 1'b0;
      req_ready = '0;
      if (rst_n_in) begin
         unique case (state_q)
            ARBITRATE: begin
               if (!fifo_full && rr_found) begin
                  sel       = rr_sel;
                  req_valid = 1'b1;
                  if (bus.mmu_request_ready_in) begin
                     push              = 1'b1;
                     req_ready[rr_sel] = 1'b1;
                     rr_d              = next_id(rr_sel);
                  end else begin
                     lock_d  = rr_sel;
                     state_d = LOCKED;
                  end
               end
            end
            LOCKED: begin
               sel       = lock_q;
               req_valid = 1'b1;
               if (bus.mmu_request_ready_in) begin
                  push              = 1'b1;
                  req_ready[lock_q] = 1'b1;
                  rr_d              = next_id(lock_q);
                  state_d           = ARBITRATE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ARBITRATE;
         rr_q    <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
      end
   end

   mmu_port_arbiter_route_fifo #(
      .WIDTH (IDW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_route_fifo (
      .clk_i   (clk_in),
      .rst_ni  (rst_n_in),
      .push_i  (push),
      .data_i  (sel),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign resp_ready = ~fifo_empty & bus.port_response_ready_in[head];
   assign pop        = bus.mmu_response_valid_in & resp_ready;

   always_comb begin
      resp_valid = '0;
      if (bus.mmu_response_valid_in && !fifo_empty) begin
         resp_valid[head] = 1'b1;
      end
   end

   assign bus.port_request_ready_out    = req_ready;
   assign bus.mmu_request_valid_out     = req_valid;
   assign bus.mmu_request_address_out   =
      req_valid ? bus.port_request_address_in[sel] : '0;
   assign bus.mmu_request_operation_out =
      req_valid ? bus.port_request_operation_in[sel] : MEM_READ;
   assign bus.mmu_request_data_out      =
      req_valid ? bus.port_request_data_in[sel] : '0;
   assign bus.mmu_response_ready_out    = resp_ready;
   assign bus.port_response_valid_out   = resp_valid;
   assign bus.port_response_data_out    = bus.mmu_response_data_in;

   a_lock_hold: assert property (
      @(posedge clk_in) disable iff (!rst_n_in)
      state_q == LOCKED |-> bus.port_request_valid_in[lock_q]);

   a_resp_when_empty: assert property (
      @(posedge clk_in) disable iff (!rst_n_in)
      bus.mmu_response_valid_in |-> !fifo_empty);

   a_count_bound: assert property (
      @(posedge clk_in) disable iff (!rst_n_in)
      fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed bench for mmu_port_arbiter.
// Two instances: 2-port and 3-port, both 4 outstanding.
module tb_mmu_port_arbiter;
   import mmu_port_arbiter_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   Word  addr_a [2];
   Word  addr_b [3];

   always #5 clk = ~clk;

   mmu_port_arbiter_if #(.NUM_PORTS(2)) a ();
   mmu_port_arbiter_if #(.NUM_PORTS(3)) b ();

   mmu_port_arbiter #(
      .NUM_PORTS       (2),
      .MAX_OUTSTANDING (4)
   ) dut_a (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (a.slave)
   );

   mmu_port_arbiter #(
      .NUM_PORTS       (3),
      .MAX_OUTSTANDING (4)
   ) dut_b (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (b.slave)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      addr_a[0] = 32'h0000_1000;
      addr_a[1] = 32'h0000_2000;
      addr_b[0] = 32'h0000_3000;
      addr_b[1] = 32'h0000_3100;
      addr_b[2] = 32'h0000_3200;

      for (int p = 0; p < 2; p++) begin
         a.port_request_address_in[p] = addr_a[p];
         a.port_request_data_in[p]    = 32'hD0D0_0000 + p;
      end
      a.port_request_operation_in[0] = MEM_READ;
      a.port_request_operation_in[1] = MEM_WRITE;
      for (int p = 0; p < 3; p++) begin
         b.port_request_address_in[p]   = addr_b[p];
         b.port_request_data_in[p]      = 32'hB0B0_0000 + p;
         b.port_request_operation_in[p] = MEM_READ;
      end

      // Valids and downstream ready are high to prove reset gating.
      a.port_request_valid_in  = 2'b11;
      a.port_response_ready_in = 2'b11;
      a.mmu_request_ready_in   = 1'b1;
      a.mmu_response_valid_in  = 1'b0;
      a.mmu_response_data_in   = '0;
      b.port_request_valid_in  = 3'b000;
      b.port_response_ready_in = 3'b111;
      b.mmu_request_ready_in   = 1'b0;
      b.mmu_response_valid_in  = 1'b0;
      b.mmu_response_data_in   = '0;

      // Reset state
      repeat (2) tick();
      check("rst_req_valid", 32'(a.mmu_request_valid_out), 0);
      check("rst_req_ready", 32'(a.port_request_ready_out), 0);
      check("rst_rsp_ready", 32'(a.mmu_response_ready_out), 0);
      check("rst_rsp_valid", 32'(a.port_response_valid_out), 0);
      check("rst_addr", a.mmu_request_address_out, 0);
      a.port_request_valid_in = 2'b00;
      rst_n = 1'b1;
      #1;
      check("idle_req_valid", 32'(a.mmu_request_valid_out), 0);
      check("idle_rsp_ready", 32'(a.mmu_response_ready_out), 0);
      tick();

      // Alternating grants with responses one cycle later
      for (int k = 0; k < 5; k++) begin
         a.port_request_valid_in = (k < 4) ? 2'b11 : 2'b00;
         a.mmu_request_ready_in  = 1'b1;
         a.mmu_response_valid_in = (k > 0);
         a.mmu_response_data_in  = 32'hA000_0000 + k;
         #1;
         if (k < 4) begin
            check("alt_addr", a.mmu_request_address_out, addr_a[k % 2]);
            check("alt_grant", 32'(a.port_request_ready_out), 1 << (k % 2));
         end else begin
            check("alt_idle", 32'(a.mmu_request_valid_out), 0);
         end
         if (k > 0) begin
            check("alt_rsp_port", 32'(a.port_response_valid_out),
                  1 << ((k - 1) % 2));
            check("alt_rsp_data", a.port_response_data_out,
                  32'hA000_0000 + k);
         end
         tick();
      end
      a.mmu_response_valid_in = 1'b0;
      #1;
      check("alt_drained", 32'(a.mmu_response_ready_out), 0);

      // Lock on port 1 under backpressure
      a.port_request_valid_in = 2'b10;
      a.mmu_request_ready_in  = 1'b0;
      #1;
      check("lock_valid", 32'(a.mmu_request_valid_out), 1);
      check("lock_addr0", a.mmu_request_address_out, addr_a[1]);
      check("lock_data", a.mmu_request_data_out, 32'hD0D0_0001);
      check("lock_op", 32'(a.mmu_request_operation_out), 32'(MEM_WRITE));
      check("lock_nogrant0", 32'(a.port_request_ready_out), 0);
      tick();
      a.port_request_valid_in = 2'b11;
      for (int c = 0; c < 2; c++) begin
         #1;
         check("lock_addr", a.mmu_request_address_out, addr_a[1]);
         check("lock_nogrant", 32'(a.port_request_ready_out), 0);
         tick();
      end
      a.mmu_request_ready_in = 1'b1;
      #1;
      check("lock_release_addr", a.mmu_request_address_out, addr_a[1]);
      check("lock_release_gnt", 32'(a.port_request_ready_out), 2);
      tick();
      a.port_request_valid_in = 2'b01;
      #1;
      check("after_lock_addr", a.mmu_request_address_out, addr_a[0]);
      check("after_lock_gnt", 32'(a.port_request_ready_out), 1);
      tick();
      a.port_request_valid_in = 2'b00;
      a.mmu_response_valid_in = 1'b1;
      a.mmu_response_data_in  = 32'h1111_1111;
      #1;
      check("lock_rsp1", 32'(a.port_response_valid_out), 2);
      tick();
      #1;
      check("lock_rsp0", 32'(a.port_response_valid_out), 1);
      tick();
      a.mmu_response_valid_in = 1'b0;

      // Fill the FIFO, then pop: next grant one cycle later
      a.port_request_valid_in = 2'b11;
      a.mmu_request_ready_in  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("fill_addr", a.mmu_request_address_out, addr_a[(k + 1) % 2]);
         check("fill_gnt", 32'(a.port_request_ready_out), 1 << ((k + 1) % 2));
         tick();
      end
      #1;
      check("full_valid", 32'(a.mmu_request_valid_out), 0);
      check("full_gnt", 32'(a.port_request_ready_out), 0);
      tick();
      a.mmu_response_valid_in = 1'b1;
      a.mmu_response_data_in  = 32'h0000_0055;
      #1;
      check("full_pop_valid", 32'(a.mmu_request_valid_out), 0);
      check("full_pop_port", 32'(a.port_response_valid_out), 2);
      tick();
      a.mmu_response_valid_in = 1'b0;
      #1;
      check("fifth_valid", 32'(a.mmu_request_valid_out), 1);
      check("fifth_addr", a.mmu_request_address_out, addr_a[1]);
      check("fifth_gnt", 32'(a.port_request_ready_out), 2);
      tick();
      a.port_request_valid_in = 2'b00;

      // Head port not ready holds the response
      a.port_response_ready_in = 2'b10;
      a.mmu_response_valid_in  = 1'b1;
      a.mmu_response_data_in   = 32'hDEAD_BEEF;
      for (int c = 0; c < 2; c++) begin
         #1;
         check("hold_rsp_ready", 32'(a.mmu_response_ready_out), 0);
         check("hold_rsp_port", 32'(a.port_response_valid_out), 1);
         tick();
      end
      a.port_response_ready_in = 2'b11;
      #1;
      check("rel_rsp_ready", 32'(a.mmu_response_ready_out), 1);
      check("rel_rsp_port", 32'(a.port_response_valid_out), 1);
      check("rel_rsp_data", a.port_response_data_out, 32'hDEAD_BEEF);
      tick();
      a.mmu_response_data_in = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("drain_port", 32'(a.port_response_valid_out),
               (c % 2 == 0) ? 2 : 1);
         tick();
      end
      a.mmu_response_valid_in = 1'b0;
      #1;
      check("drain_empty", 32'(a.mmu_response_ready_out), 0);

      // Async reset while LOCKED with one request in flight
      a.port_request_valid_in = 2'b01;
      a.mmu_request_ready_in  = 1'b1;
      #1;
      check("pre_rst_gnt", 32'(a.port_request_ready_out), 1);
      tick();
      a.port_request_valid_in = 2'b10;
      a.mmu_request_ready_in  = 1'b0;
      tick();
      #1;
      check("pre_rst_locked", a.mmu_request_address_out, addr_a[1]);
      check("pre_rst_rsp_rdy", 32'(a.mmu_response_ready_out), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(a.mmu_request_valid_out), 0);
      check("mid_rst_gnt", 32'(a.port_request_ready_out), 0);
      check("mid_rst_rsp_rdy", 32'(a.mmu_response_ready_out), 0);
      tick();
      a.port_request_valid_in = 2'b00;
      rst_n = 1'b1;
      #1;
      check("post_rst_rsp_rdy", 32'(a.mmu_response_ready_out), 0);
      check("post_rst_valid", 32'(a.mmu_request_valid_out), 0);
      tick();

      // Three ports: wrap of rr pointer after granting port 2
      b.port_request_valid_in = 3'b100;
      b.mmu_request_ready_in  = 1'b1;
      #1;
      check("p3_addr2", b.mmu_request_address_out, addr_b[2]);
      check("p3_gnt2", 32'(b.port_request_ready_out), 4);
      tick();
      b.port_request_valid_in = 3'b110;
      b.mmu_response_valid_in = 1'b1;
      b.mmu_response_data_in  = 32'h0000_0077;
      #1;
      check("p3_wrap_gnt", 32'(b.port_request_ready_out), 2);
      check("p3_wrap_addr", b.mmu_request_address_out, addr_b[1]);
      check("p3_rsp2", 32'(b.port_response_valid_out), 4);
      tick();
      b.port_request_valid_in = 3'b000;
      #1;
      check("p3_rsp1", 32'(b.port_response_valid_out), 2);
      tick();
      b.mmu_response_valid_in = 1'b0;
      #1;
      check("p3_empty", 32'(b.mmu_response_ready_out), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Parametrised N-to-1 arbiter between processor-side MMU request/response channels and a single downstream MMU/memory port.
- Generalises the fixed instruction-port plus data-port pair that the core currently exposes; the core can then share one memory interface among fetch, load/store and future requesters (e.g. page-table walker, prefetcher).
- Provides round-robin arbitration, grant locking under backpressure, and in-order response routing via an internal port-ID FIFO.

Parameters:
- NUM_PORTS, 2, number of requester channels (>=2); port 0 is fetch by convention.
- MAX_OUTSTANDING, 4, maximum in-flight requests awaiting response; power of two, >=1.
- PORT_ID_WIDTH, $clog2(NUM_PORTS), width of routing tag (derived, not overridden).

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- port_request_valid_in  input  NUM_PORTS  per-port request valid.
- port_request_ready_out  output  NUM_PORTS  per-port request accepted this cycle.
- port_request_address_in  input  NUM_PORTS x Word  per-port address.
- port_request_operation_in  input  NUM_PORTS x MemoryOperation  per-port operation.
- port_request_data_in  input  NUM_PORTS x Word  per-port store data.
- port_response_ready_in  input  NUM_PORTS  per-port response ready.
- port_response_valid_out  output  NUM_PORTS  per-port response valid (at most one bit set).
- port_response_data_out  output  Word  response data, shared by all ports.
- mmu_request_ready_in  input  1  downstream accepts request.
- mmu_request_valid_out  output  1  downstream request valid.
- mmu_request_address_out  output  Word  granted address.
- mmu_request_operation_out  output  MemoryOperation  granted operation.
- mmu_request_data_out  output  Word  granted data.
- mmu_response_ready_out  output  1  arbiter accepts downstream response.
- mmu_response_valid_in  input  1  downstream response valid.
- mmu_response_data_in  input  Word  downstream response data.

Behaviour:
- Handshake: transfer occurs when valid & ready are both high on a rising edge. Every request (read or write) yields exactly one response, in issue order.
- Reset (rst_n_in low, asynchronous): FSM=ARBITRATE, rr_pointer=0, FIFO empty (count=0), locked port=0. All valid/ready outputs 0. Data outputs are don't-care but driven to 0.
- FSM ARBITRATE:
  - If FIFO is full, no grant is made and mmu_request_valid_out=0.
  - Otherwise select the first valid port searching upward from rr_pointer, with wrap-around. Drive its payload and assert mmu_request_valid_out combinationally.
  - If mmu_request_ready_in is high: the transfer occurs, port_request_ready_out[g]=1, the ID is pushed, rr_pointer=(g+1) mod NUM_PORTS, and the FSM stays in ARBITRATE.
  - If mmu_request_ready_in is low: latch g into locked_port and go to LOCKED.
- FSM LOCKED:
  - Output the payload from locked_port only; no re-arbitration.
  - On mmu_request_ready_in: transfer, push, update rr_pointer, return to ARBITRATE.
  - A requester deasserting valid while locked violates protocol (assertion). The arbiter does not drop the request.
- Request path latency: 0 cycles (combinational pass-through). Response path latency: 0 cycles.
- Response routing:
  - mmu_response_ready_out = FIFO non-empty & port_response_ready_in[head].
  - port_response_valid_out[head] = mmu_response_valid_in & FIFO non-empty; all other bits 0.
  - port_response_data_out = mmu_response_data_in.
  - Pop on a downstream response transfer.
- FIFO empty: mmu_response_ready_out=0. A response arriving while empty is never accepted (assertion flags it).
- FIFO full: no new grant, even if a pop occurs the same cycle. This avoids a ready-to-valid combinational path.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: in-flight IDs are discarded. The downstream is reset in the same domain.

Decomposition:
- processor_help supplies the existing Word and MemoryOperation types, plus a new ArbiterState enum {ARBITRATE, LOCKED}.
- Sub-module route_fifo (parameters WIDTH, DEPTH): synchronous FIFO with full/empty/count and async active-low reset. It is reused later for the reorder path.

Test Plan:
- Reset release, all idle -> all valid/ready outputs 0, count=0.
- Ports 0 and 1 both valid continuously, mmu ready=1, immediate responses -> grants alternate 0,1,0,1; each response is returned to the correct port.
- Port 1 wins; mmu ready held low for 3 cycles while port 0 also becomes valid -> address stays port 1's for all 3 cycles; port 1 is granted on cycle 4, then port 0.
- MAX_OUTSTANDING=4, no responses -> exactly 4 grants, then mmu_request_valid_out=0. One response arrives -> the fifth grant occurs on the next cycle, not the same cycle.
- Responses held back while port_response_ready_in[head]=0 -> mmu_response_ready_out=0 and no pop; on release, data 0xDEADBEEF is delivered to the head port only.
- NUM_PORTS=3, only port 2 valid with rr_pointer=0 -> port 2 granted and rr_pointer wraps to 0. Asynchronous reset asserted mid-LOCKED -> outputs go to 0 immediately and FIFO is empty.
